// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game datapath: control encodings,
// difficulty levels, default sequence depth and the pattern legality rule.
package simon_pkg;

   localparam logic [1:0] SEL_PLAYBACK = 2'b00;
   localparam logic [1:0] SEL_REPEAT   = 2'b01;
   localparam logic [1:0] SEL_DONE     = 2'b10;

   localparam logic LEVEL_EASY = 1'b0;
   localparam logic LEVEL_HARD = 1'b1;

   localparam int DEFAULT_DEPTH = 64;

   // Easy games allow a single switch only; hard games allow any non-blank pattern.
   function automatic logic pattern_legal(input logic level, input logic [3:0] pattern);
      if (level == LEVEL_HARD) begin
         return pattern != 4'b0000;
      end
      return $onehot(pattern);
   endfunction

endpackage

// File: rtl/simon_datapath_if.sv
// Control/status bundle between the Simon controller (master) and the
// datapath (slave).
interface simon_datapath_if;

   logic       level;
   logic [3:0] pattern;
   logic [1:0] select;
   logic       clrcount;
   logic       w_en;
   logic       is_legal;
   logic       play_gt_count;
   logic       repeat_eq_play;
   logic       input_eq_pattern;
   logic [3:0] pattern_leds;

   modport master (
      output level, pattern, select, clrcount, w_en,
      input  is_legal, play_gt_count, repeat_eq_play, input_eq_pattern, pattern_leds
   );

   modport slave (
      input  level, pattern, select, clrcount, w_en,
      output is_legal, play_gt_count, repeat_eq_play, input_eq_pattern, pattern_leds
   );

endinterface

// File: rtl/simon_memory.sv
// Sequence storage: DEPTH x 4 entries, synchronous write, two combinational
// read ports (one for the repeat comparison, one for the LED view).
module simon_memory #(
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [3:0]    wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [3:0]    rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [3:0]    rdata_b
);

   logic [3:0] mem [DEPTH];

   // Contents are deliberately not reset; validity is tracked by the count register.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/simon_datapath.sv
// Simon game datapath: records the player's sequence, walks it for playback,
// repeat checking and the final "done" display, and raises status flags.
module simon_datapath
   import simon_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input logic             clk,
   input logic             rst,
   simon_datapath_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = AW + 1;
   localparam logic [IW-1:0] FULL = IW'(DEPTH);
   localparam logic [IW-1:0] ONE  = IW'(1);

   logic [IW-1:0] count;
   logic [IW-1:0] play_idx;
   logic [IW-1:0] rep_idx;
   logic [IW-1:0] done_idx;
   logic [IW-1:0] last_idx;
   logic          legal;
   logic          has_entries;
   logic          mem_we;
   logic [AW-1:0] view_addr;
   logic [3:0]    rep_data;
   logic [3:0]    view_data;

   assign legal       = pattern_legal(bus.level, bus.pattern);
   assign has_entries = count != '0;
   assign last_idx    = count - ONE;
   assign mem_we      = bus.w_en && legal && (count < FULL) && !bus.clrcount && !rst;
   assign view_addr   = (bus.select == SEL_PLAYBACK) ? play_idx[AW-1:0] : done_idx[AW-1:0];

   simon_memory #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we),
      .waddr   (count[AW-1:0]),
      .wdata   (bus.pattern),
      .raddr_a (rep_idx[AW-1:0]),
      .rdata_a (rep_data),
      .raddr_b (view_addr),
      .rdata_b (view_data)
   );

   // Reset and clrcount share top priority; input mode beats the select-driven walks.
   always_ff @(posedge clk) begin
      if (rst || bus.clrcount) begin
         count    <= '0;
         play_idx <= '0;
         rep_idx  <= '0;
         done_idx <= '0;
      end else if (bus.w_en) begin
         if (legal && (count < FULL)) begin
            count <= count + ONE;
         end
         play_idx <= '0;
         rep_idx  <= '0;
         done_idx <= '0;
      end else begin
         case (bus.select)
            SEL_PLAYBACK: begin
               if (play_idx < count) begin
                  play_idx <= play_idx + ONE;
               end
               rep_idx <= '0;
            end
            SEL_REPEAT: begin
               if (has_entries && (rep_idx < last_idx)) begin
                  rep_idx <= rep_idx + ONE;
               end
            end
            default: begin
               if (!has_entries || (done_idx >= last_idx)) begin
                  done_idx <= '0;
               end else begin
                  done_idx <= done_idx + ONE;
               end
            end
         endcase
      end
   end

   assign bus.is_legal         = legal;
   assign bus.play_gt_count    = play_idx >= count;
   assign bus.repeat_eq_play   = has_entries && (rep_idx == last_idx);
   assign bus.input_eq_pattern = has_entries && (rep_idx < count) && (bus.pattern == rep_data);

   // Stale entries beyond count are blanked so they never reach the LEDs.
   always_comb begin
      bus.pattern_leds = 4'b0000;
      if (bus.w_en) begin
         bus.pattern_leds = bus.pattern;
      end else begin
         case (bus.select)
            SEL_PLAYBACK: bus.pattern_leds = (play_idx >= count) ? 4'b0000 : view_data;
            SEL_REPEAT:   bus.pattern_leds = bus.pattern;
            default:      bus.pattern_leds = has_entries ? view_data : 4'b0000;
         endcase
      end
   end

endmodule

// File: tb/tb_simon_datapath.sv
// Directed self-checking bench for simon_datapath with hand-computed expectations.
module tb_simon_datapath;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   simon_datapath_if bus ();

   simon_datapath #(
      .DEPTH (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_sequence();
      logic [3:0] seq [3];
      seq[0] = 4'b0001;
      seq[1] = 4'b0010;
      seq[2] = 4'b0100;
      bus.w_en     = 1'b0;
      bus.clrcount = 1'b1;
      tick();
      bus.clrcount = 1'b0;
      bus.w_en     = 1'b1;
      bus.level    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.pattern = seq[i];
         tick();
      end
      bus.w_en = 1'b0;
      checks++;
      if (dut.count !== 7'd3) begin
         errors++;
         $display("[TB] FAIL load_count got=%0d want=3", dut.count);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.level    = 1'b0;
      bus.pattern  = 4'b0000;
      bus.select   = 2'b00;
      bus.clrcount = 1'b0;
      bus.w_en     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.play_gt_count !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_play_gt got=%b want=1", bus.play_gt_count);
      end
      checks++;
      if (bus.repeat_eq_play !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_repeat_eq got=%b want=0", bus.repeat_eq_play);
      end
      checks++;
      if (bus.input_eq_pattern !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_input_eq got=%b want=0", bus.input_eq_pattern);
      end
      checks++;
      if (bus.pattern_leds !== 4'b0000 || bus.is_legal !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_leds_legal got=%b/%b want=0000/0", bus.pattern_leds, bus.is_legal);
      end
      checks++;
      if (dut.count !== 7'd0) begin
         errors++;
         $display("[TB] FAIL reset_count got=%0d want=0", dut.count);
      end
   endtask

   task automatic test_write_legality();
      bus.level   = 1'b0;
      bus.w_en    = 1'b1;
      bus.pattern = 4'b0011;
      #1;
      checks++;
      if (bus.is_legal !== 1'b0) begin
         errors++;
         $display("[TB] FAIL easy_two_bits_legal got=%b want=0", bus.is_legal);
      end
      tick();
      checks++;
      if (dut.count !== 7'd0) begin
         errors++;
         $display("[TB] FAIL illegal_no_write_count got=%0d want=0", dut.count);
      end
      bus.pattern = 4'b0100;
      #1;
      checks++;
      if (bus.is_legal !== 1'b1 || bus.pattern_leds !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL easy_one_bit got=%b/%b want=1/0100", bus.is_legal, bus.pattern_leds);
      end
      tick();
      checks++;
      if (dut.count !== 7'd1 || dut.u_mem.mem[0] !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL first_write got=%0d/%b want=1/0100", dut.count, dut.u_mem.mem[0]);
      end
      bus.w_en = 1'b0;
   endtask

   task automatic test_fill();
      bus.clrcount = 1'b1;
      tick();
      bus.clrcount = 1'b0;
      bus.level    = 1'b1;
      bus.pattern  = 4'b1111;
      bus.w_en     = 1'b1;
      for (int i = 0; i < 64; i++) begin
         tick();
      end
      checks++;
      if (dut.count !== 7'd64) begin
         errors++;
         $display("[TB] FAIL fill_count got=%0d want=64", dut.count);
      end
      checks++;
      if (bus.is_legal !== 1'b1) begin
         errors++;
         $display("[TB] FAIL full_is_legal got=%b want=1", bus.is_legal);
      end
      tick();
      checks++;
      if (dut.count !== 7'd64 || bus.is_legal !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overflow_write got=%0d/%b want=64/1", dut.count, bus.is_legal);
      end
      bus.w_en = 1'b0;
   endtask

   task automatic test_playback();
      logic [3:0] exp_leds [5];
      logic       exp_gt   [5];
      exp_leds[0] = 4'b0001; exp_gt[0] = 1'b0;
      exp_leds[1] = 4'b0010; exp_gt[1] = 1'b0;
      exp_leds[2] = 4'b0100; exp_gt[2] = 1'b0;
      exp_leds[3] = 4'b0000; exp_gt[3] = 1'b1;
      exp_leds[4] = 4'b0000; exp_gt[4] = 1'b1;
      bus.w_en   = 1'b0;
      bus.select = 2'b00;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.pattern_leds !== exp_leds[i] || bus.play_gt_count !== exp_gt[i]) begin
            errors++;
            $display("[TB] FAIL playback_%0d got=%b/%b want=%b/%b", i,
                     bus.pattern_leds, bus.play_gt_count, exp_leds[i], exp_gt[i]);
         end
         if (i < 4) tick();
      end
   endtask

   task automatic test_repeat();
      logic [3:0] seq [3];
      seq[0] = 4'b0001;
      seq[1] = 4'b0010;
      seq[2] = 4'b0100;
      bus.select = 2'b01;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            bus.pattern = 4'b1000;
            #1;
            checks++;
            if (bus.input_eq_pattern !== 1'b0) begin
               errors++;
               $display("[TB] FAIL repeat_wrong_input got=%b want=0", bus.input_eq_pattern);
            end
         end
         bus.pattern = seq[i];
         #1;
         checks++;
         if (bus.input_eq_pattern !== 1'b1 || bus.repeat_eq_play !== (i == 2)) begin
            errors++;
            $display("[TB] FAIL repeat_%0d got=%b/%b want=1/%b", i,
                     bus.input_eq_pattern, bus.repeat_eq_play, (i == 2));
         end
         checks++;
         if (bus.pattern_leds !== seq[i]) begin
            errors++;
            $display("[TB] FAIL repeat_leds_%0d got=%b want=%b", i, bus.pattern_leds, seq[i]);
         end
         tick();
      end
      checks++;
      if (dut.rep_idx !== 7'd2 || bus.repeat_eq_play !== 1'b1) begin
         errors++;
         $display("[TB] FAIL repeat_saturate got=%0d/%b want=2/1", dut.rep_idx, bus.repeat_eq_play);
      end
   endtask

   task automatic test_done();
      logic [3:0] exp_leds [5];
      exp_leds[0] = 4'b0001;
      exp_leds[1] = 4'b0010;
      exp_leds[2] = 4'b0100;
      exp_leds[3] = 4'b0001;
      exp_leds[4] = 4'b0010;
      bus.select = 2'b10;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.pattern_leds !== exp_leds[i]) begin
            errors++;
            $display("[TB] FAIL done_%0d got=%b want=%b", i, bus.pattern_leds, exp_leds[i]);
         end
         tick();
      end
      bus.select = 2'b11;
      #1;
      checks++;
      if (bus.pattern_leds !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL done_sel11 got=%b want=0100", bus.pattern_leds);
      end
      tick();
      checks++;
      if (bus.pattern_leds !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL done_sel11_wrap got=%b want=0001", bus.pattern_leds);
      end
   endtask

   task automatic test_clrcount_write();
      bus.clrcount = 1'b1;
      bus.w_en     = 1'b1;
      bus.level    = 1'b0;
      bus.pattern  = 4'b1000;
      tick();
      bus.clrcount = 1'b0;
      bus.w_en     = 1'b0;
      checks++;
      if (dut.count !== 7'd0 || dut.u_mem.mem[3] !== 4'b1111) begin
         errors++;
         $display("[TB] FAIL clrcount_priority got=%0d/%b want=0/1111", dut.count, dut.u_mem.mem[3]);
      end
   endtask

   task automatic test_mid_repeat_reset();
      load_sequence();
      bus.select = 2'b00;
      tick();
      bus.select = 2'b01;
      tick();
      tick();
      checks++;
      if (dut.rep_idx !== 7'd2) begin
         errors++;
         $display("[TB] FAIL mid_repeat_idx got=%0d want=2", dut.rep_idx);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (dut.rep_idx !== 7'd0 || dut.count !== 7'd0 || bus.play_gt_count !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_repeat_reset got=%0d/%0d/%b want=0/0/1",
                  dut.rep_idx, dut.count, bus.play_gt_count);
      end
      rst = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_write_legality();
      test_fill();
      load_sequence();
      test_playback();
      test_repeat();
      test_done();
      test_clrcount_write();
      test_mid_repeat_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/simon_datapath.md
SIMON_DATAPATH -- requirements
Module: simon_datapath

Interface
REQ-001 The block SHALL have the port: clk  input  1  step clock; each rising edge is one player step.
REQ-002 The block SHALL have the port: rst  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have the port: level  input  1  difficulty (0 = easy, 1 = hard).
REQ-004 The block SHALL have the port: pattern  input  4  player switch pattern.
REQ-005 The block SHALL have the port: select  input  2  LED source from control: 00 = playback, 01 = repeat, 10 = done, 11 = treat as done.
REQ-006 The block SHALL have the port: clrcount  input  1  clear the sequence length and all indices.
REQ-007 The block SHALL have the port: w_en  input  1  input mode, active; overrides select.
REQ-008 The block SHALL have the port: is_legal  output  1  pattern is legal for the current level.
REQ-009 The block SHALL have the port: play_gt_count  output  1  playback has passed the last stored entry.
REQ-010 The block SHALL have the port: repeat_eq_play  output  1  repeat index is at the last stored entry.
REQ-011 The block SHALL have the port: input_eq_pattern  output  1  pattern equals the stored entry at the repeat index.
REQ-012 The block SHALL have the port: pattern_leds  output  4  displayed pattern.
REQ-013 The block SHALL have the parameter: DEPTH, default 64, sequence capacity, which SHALL be a power of two.

Function
REQ-014 The block SHALL hold a DEPTH x 4 sequence memory with synchronous write and combinational read.
REQ-015 The block SHALL hold the registers count (0..DEPTH, width clog2(DEPTH)+1), play_idx, rep_idx and done_idx (each clog2(DEPTH)+1 wide).
REQ-016 is_legal SHALL be combinational: level 0 requires exactly one bit of pattern set; level 1 requires pattern != 0.
REQ-017 On a clk edge with w_en=1 and is_legal=1 and count<DEPTH, the block SHALL write pattern to mem[count] and increment count.
REQ-018 On a clk edge with w_en=1 and count==DEPTH, the block SHALL suppress the write, hold count, and still drive is_legal per REQ-016.
REQ-019 While w_en=1 on a clk edge, the block SHALL clear play_idx, rep_idx and done_idx to 0.
REQ-020 While w_en=0 and select=00 on a clk edge, play_idx SHALL increment, saturating at count, and rep_idx SHALL clear to 0.
REQ-021 While w_en=0 and select=01 on a clk edge, rep_idx SHALL increment, saturating at count-1 when count>0.
REQ-022 While w_en=0 and select is 10 or 11 on a clk edge, done_idx SHALL increment and wrap to 0 after count-1; done_idx SHALL stay 0 if count==0.
REQ-023 play_gt_count SHALL be asserted when play_idx >= count, so it is 1 immediately when count==0.
REQ-024 repeat_eq_play SHALL be asserted when count>0 and rep_idx == count-1.
REQ-025 input_eq_pattern SHALL be asserted when pattern == mem[rep_idx]; it SHALL be 0 when count==0.
REQ-026 pattern_leds selection SHALL be: w_en=1 -> pattern; select 00 -> mem[play_idx], or 0000 if play_idx>=count; select 01 -> pattern; select 10 or 11 -> mem[done_idx].
REQ-027 All flags SHALL be combinational from registers and inputs, with zero latency.
REQ-028 clrcount=1 on a clk edge SHALL zero count and all indices, SHALL take priority over all updates in the same cycle, and SHALL suppress any write.
REQ-029 The block SHALL leave memory contents unaffected by clrcount and rst; entries at index >= count SHALL never be read as valid.

Reset
REQ-030 rst=1 on a clk edge SHALL zero count, play_idx, rep_idx and done_idx, with the same priority as clrcount.
REQ-031 After reset, outputs SHALL read: play_gt_count=1, repeat_eq_play=0, input_eq_pattern=0; pattern_leds and is_legal SHALL follow REQ-026 and REQ-016.
REQ-032 A rst asserted mid-playback or mid-repeat SHALL take effect on that same edge.

Structure
REQ-033 A shared package simon_pkg SHALL hold the select encodings (SEL_PLAYBACK=00, SEL_REPEAT=01, SEL_DONE=10), LEVEL_EASY/LEVEL_HARD, and the default depth 64.
REQ-034 The memory SHALL be a single sub-module, simon_memory (DEPTH x 4, synchronous write, combinational read).

Verification
REQ-035 The bench SHALL check: level=0, w_en=1, pattern=0011 -> is_legal=0, count stays 0; then pattern=0100 for 1 edge -> count=1 and mem[0]=0100.
REQ-036 The bench SHALL check: count=3 holding {0001,0010,0100}, select=00 for 4 edges -> pattern_leds reads 0001, 0010, 0100, then 0000 with play_gt_count=1.
REQ-037 The bench SHALL check: select=01, patterns 0001 then 0010 then 0100 -> input_eq_pattern=1 each cycle and repeat_eq_play=1 on the third cycle; pattern=1000 in the second cycle -> input_eq_pattern=0.
REQ-038 The bench SHALL check: select=10 with count=3 for 5 edges -> pattern_leds cycles 0001, 0010, 0100, 0001, 0010.
REQ-039 The bench SHALL check: fill DEPTH=64 entries with level=1 and pattern=1111 -> count=64, a 65th write is suppressed, and is_legal stays 1.
REQ-040 The bench SHALL check: clrcount=1 together with w_en=1 and a legal pattern -> count=0 with no write; rst asserted mid-repeat with rep_idx=2 -> rep_idx=0 on the same edge.
